// File: rtl/life_step_controller.sv
// Step sequencer for the game-of-life engine: debounced run/pause and step/speed
// buttons, a speed-scaled tick timer and a req/ack step handshake with generation count.
module life_step_controller #(
  parameter int unsigned BASE_PERIOD     = 13_333_333,
  parameter int unsigned DEBOUNCE_CYCLES = 400_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        step_ack,
  output logic        step_req,
  output logic        running,
  output logic [1:0]  speed,
  output logic [15:0] generation
);

  localparam int unsigned TW = $clog2(BASE_PERIOD);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, REQ} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] last_tick_c;
  logic [1:0]    raw;
  logic [1:0]    press;
  logic          left_ev;
  logic          right_ev;

  assign raw = {right, left};

  // Per button: 2-flop synchronizer, stability filter and a one-cycle press pulse on 0->1.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          press_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        level   <= 1'b0;
        press_q <= 1'b0;
        cnt     <= '0;
      end else begin
        sync1   <= raw[g];
        sync2   <= sync1;
        press_q <= 1'b0;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          level   <= sync2;
          cnt     <= '0;
          press_q <= sync2;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign press[g] = press_q;
  end

  // A simultaneous left event wins; the right event is discarded.
  assign left_ev  = press[0];
  assign right_ev = press[1] & ~press[0];

  // Final timer value for the current speed: (BASE_PERIOD >> speed) - 1.
  always_comb begin
    last_tick_c = TW'(BASE_PERIOD - 1);
    case (speed)
      2'd0: last_tick_c = TW'(BASE_PERIOD - 1);
      2'd1: last_tick_c = TW'((BASE_PERIOD >> 1) - 1);
      2'd2: last_tick_c = TW'((BASE_PERIOD >> 2) - 1);
      2'd3: last_tick_c = TW'((BASE_PERIOD >> 3) - 1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      step_req   <= 1'b0;
      running    <= 1'b0;
      speed      <= 2'd0;
      generation <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (left_ev) begin
            running <= 1'b1;
            timer   <= '0;
            state   <= RUN;
          end else if (right_ev) begin
            step_req <= 1'b1;
            state    <= REQ;
          end
        end
        RUN: begin
          if (left_ev) begin
            running <= 1'b0;
            timer   <= '0;
            state   <= IDLE;
          end else if (right_ev) begin
            speed <= speed + 2'd1;
            timer <= '0;
          end else if (timer == last_tick_c) begin
            timer    <= '0;
            step_req <= 1'b1;
            state    <= REQ;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REQ: begin
          timer <= '0;
          if (left_ev) begin
            running <= ~running;
          end else if (right_ev && running) begin
            speed <= speed + 2'd1;
          end
          // Return state follows the run flag as updated in this same cycle.
          if (step_ack) begin
            generation <= generation + 16'd1;
            step_req   <= 1'b0;
            state      <= (running ^ left_ev) ? RUN : IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          step_req <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule
